mac_pe: RTL

Parametrised multiply-accumulate processing element for the NPU compute array. It generalises the single-mode 8×8 MAC cell with configurable operand and accumulator widths, selectable pixel signedness, and a double-buffered stationary weight. It adds valid qualification, saturating arithmetic, and a second output-stationary accumulation mode. Pixels are forwarded with one cycle of delay so PEs tile into a systolic row; partial sums chain column-wise in mode 0.

---
 rtl/mac_pe_if.sv | 31 +++
 rtl/mac_pe.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mac_pe_if.sv
// Bus bundle between a mac_pe and its neighbours / array controller.
// master drives operands and weight control; slave is the PE itself.
interface mac_pe_if #(
    parameter int PIX_W = 8,
    parameter int WGT_W = 8,
    parameter int ACC_W = 18
);
    logic             mode;
    logic             wgt_load;
    logic             wgt_swap;
    logic [WGT_W-1:0] wgt_in;
    logic             in_valid;
    logic             in_last;
    logic [PIX_W-1:0] pixel_in;
    logic [ACC_W-1:0] sum_in;
    logic [PIX_W-1:0] pixel_out;
    logic             pix_valid_out;
    logic [ACC_W-1:0] sum_out;
    logic             out_valid;
    logic             sat_flag;

    modport master (
        output mode, wgt_load, wgt_swap, wgt_in, in_valid, in_last, pixel_in, sum_in,
        input  pixel_out, pix_valid_out, sum_out, out_valid, sat_flag
    );

    modport slave (
        input  mode, wgt_load, wgt_swap, wgt_in, in_valid, in_last, pixel_in, sum_in,
        output pixel_out, pix_valid_out, sum_out, out_valid, sat_flag
    );
endinterface

// File: rtl/mac_pe.sv
// Multiply-accumulate processing element: chain mode (prod + sum_in) or
// local output-stationary accumulation, saturating, with a double-buffered
// stationary weight and one-cycle pixel forwarding for systolic tiling.
module mac_pe #(
    parameter int PIX_W      = 8,
    parameter int WGT_W      = 8,
    parameter int ACC_W      = 18,
    parameter bit PIX_SIGNED = 1'b0
) (
    input logic   clk,
    input logic   rst,
    mac_pe_if.slave bus
);
    localparam int PROD_W = PIX_W + WGT_W + 1;
    // Wide enough for either operand plus one carry bit; equals ACC_W+1
    // whenever the accumulator is at least as wide as the product.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        MODE_CHAIN = 1'b0,
        MODE_ACC   = 1'b1
    } mode_e;

    logic signed [WGT_W-1:0] wgt_act_q, wgt_act_d;
    logic signed [WGT_W-1:0] wgt_shd_q, wgt_shd_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic [PIX_W-1:0]        pix_q, pix_d;
    logic                    pixv_q, pixv_d;
    logic                    ov_q, ov_d;
    logic                    sat_q, sat_d;

    mode_e                    mode_s;
    logic signed [PIX_W:0]    pix_ext;
    logic signed [PROD_W-1:0] pix_x;
    logic signed [PROD_W-1:0] wgt_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  base;
    logic signed [SUM_W-1:0]  sum_full;
    logic signed [ACC_W-1:0]  clamped;
    logic                     sat_now;

    // Datapath: extend pixel, full-precision product, widened sum, clamp.
    always_comb begin
        mode_s   = mode_e'(bus.mode);
        pix_ext  = {(PIX_SIGNED ? bus.pixel_in[PIX_W-1] : 1'b0), bus.pixel_in};
        pix_x    = PROD_W'(pix_ext);
        wgt_x    = PROD_W'(wgt_act_q);
        prod     = pix_x * wgt_x;
        base     = (mode_s == MODE_ACC) ? acc_q : $signed(bus.sum_in);
        sum_full = SUM_W'(base) + SUM_W'(prod);
        sat_now  = 1'b0;
        if (sum_full > SUM_W'(ACC_MAX)) begin
            clamped = ACC_MAX;
            sat_now = 1'b1;
        end else if (sum_full < SUM_W'(ACC_MIN)) begin
            clamped = ACC_MIN;
            sat_now = 1'b1;
        end else begin
            clamped = ACC_W'(sum_full);
        end
    end

    // Next-state: weight buffers, pixel forward, mode-dependent result/accumulator.
    always_comb begin
        wgt_shd_d = bus.wgt_load ? $signed(bus.wgt_in) : wgt_shd_q;
        wgt_act_d = bus.wgt_swap ? wgt_shd_q : wgt_act_q;
        pix_d     = bus.pixel_in;
        pixv_d    = bus.in_valid;
        acc_d     = acc_q;
        sum_d     = sum_q;
        ov_d      = 1'b0;
        sat_d     = sat_q;
        if (bus.in_valid) begin
            sat_d = sat_q | sat_now;
            unique case (mode_s)
                MODE_CHAIN: begin
                    // A chain beat abandons any partial local window.
                    sum_d = clamped;
                    ov_d  = 1'b1;
                    acc_d = '0;
                end
                MODE_ACC: begin
                    if (bus.in_last) begin
                        sum_d = clamped;
                        ov_d  = 1'b1;
                        acc_d = '0;
                    end else begin
                        acc_d = clamped;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wgt_act_q <= '0;
            wgt_shd_q <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            pix_q     <= '0;
            pixv_q    <= 1'b0;
            ov_q      <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            wgt_act_q <= wgt_act_d;
            wgt_shd_q <= wgt_shd_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            pix_q     <= pix_d;
            pixv_q    <= pixv_d;
            ov_q      <= ov_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.pixel_out     = pix_q;
    assign bus.pix_valid_out = pixv_q;
    assign bus.sum_out       = sum_q;
    assign bus.out_valid     = ov_q;
    assign bus.sat_flag      = sat_q;
endmodule
